// File: rtl/ocp_slave_slice.sv
// Registered OCP stage in front of a single slave: one command in flight, replayed
// until the slave accepts, response returned as a one-cycle pulse, watchdog -> ERR.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE 3'b000
`endif
`ifndef OCP_CMD_WR
`define OCP_CMD_WR 3'b001
`endif
`ifndef OCP_CMD_RD
`define OCP_CMD_RD 3'b010
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`endif
`ifndef OCP_RESP_DVA
`define OCP_RESP_DVA 2'b01
`endif
`ifndef OCP_RESP_ERR
`define OCP_RESP_ERR 2'b11
`endif

module ocp_slave_slice #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [`ADDR_WIDTH-1:0] i_MAddr,
   input  logic [2:0]             i_MCmd,
   input  logic [`DATA_WIDTH-1:0] i_MData,
   input  logic [`BEN_WIDTH-1:0]  i_MByteEn,
   output logic                   o_SCmdAccept,
   output logic [`DATA_WIDTH-1:0] o_SData,
   output logic [1:0]             o_SResp,
   output logic [`ADDR_WIDTH-1:0] o_MAddr,
   output logic [2:0]             o_MCmd,
   output logic [`DATA_WIDTH-1:0] o_MData,
   output logic [`BEN_WIDTH-1:0]  o_MByteEn,
   input  logic                   i_SCmdAccept,
   input  logic [`DATA_WIDTH-1:0] i_SData,
   input  logic [1:0]             i_SResp
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

   localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

   state_e                   state_q, state_d;
   logic [`ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [2:0]               cmd_q, cmd_d;
   logic [`DATA_WIDTH-1:0]   data_q, data_d;
   logic [`BEN_WIDTH-1:0]    ben_q, ben_d;
   logic [`DATA_WIDTH-1:0]   sdata_q, sdata_d;
   logic [1:0]               sresp_q, sresp_d;
   logic [15:0]              cnt_q, cnt_d;
   logic                     timeout_hit;

   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cmd_d   = cmd_q;
      data_d  = data_q;
      ben_d   = ben_q;
      sdata_d = sdata_q;
      sresp_d = sresp_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (i_MCmd != `OCP_CMD_IDLE) begin
               addr_d  = i_MAddr;
               cmd_d   = i_MCmd;
               data_d  = i_MData;
               ben_d   = i_MByteEn;
               cnt_d   = 16'd0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // A response in the accept cycle completes, and completion beats the watchdog.
            if (i_SCmdAccept && (i_SResp != `OCP_RESP_NULL)) begin
               sdata_d = i_SData;
               sresp_d = i_SResp;
               state_d = S_RESP;
            end else if (timeout_hit) begin
               sdata_d = '0;
               sresp_d = `OCP_RESP_ERR;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
               if (i_SCmdAccept) state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_SResp != `OCP_RESP_NULL) begin
               sdata_d = i_SData;
               sresp_d = i_SResp;
               state_d = S_RESP;
            end else if (timeout_hit) begin
               sdata_d = '0;
               sresp_d = `OCP_RESP_ERR;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cmd_q   <= `OCP_CMD_IDLE;
         data_q  <= '0;
         ben_q   <= '0;
         sdata_q <= '0;
         sresp_q <= `OCP_RESP_NULL;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cmd_q   <= cmd_d;
         data_q  <= data_d;
         ben_q   <= ben_d;
         sdata_q <= sdata_d;
         sresp_q <= sresp_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode the state so an async reset drops the slave command immediately.
   assign o_SCmdAccept = (state_q == S_IDLE) && !rst;
   assign o_MCmd       = (state_q == S_REQ) ? cmd_q : `OCP_CMD_IDLE;
   assign o_MAddr      = addr_q;
   assign o_MData      = data_q;
   assign o_MByteEn    = ben_q;
   assign o_SResp      = (state_q == S_RESP) ? sresp_q : `OCP_RESP_NULL;
   assign o_SData      = (state_q == S_RESP) ? sdata_q : '0;

endmodule

// File: tb/tb_ocp_slave_slice.sv
// Directed bench for ocp_slave_slice: inputs change and outputs are checked just
// after the falling edge; one DUT with TIMEOUT=8 and one with the watchdog disabled.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE 3'b000
`endif
`ifndef OCP_CMD_WR
`define OCP_CMD_WR 3'b001
`endif
`ifndef OCP_CMD_RD
`define OCP_CMD_RD 3'b010
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`endif
`ifndef OCP_RESP_DVA
`define OCP_RESP_DVA 2'b01
`endif
`ifndef OCP_RESP_ERR
`define OCP_RESP_ERR 2'b11
`endif

module tb_ocp_slave_slice;

   logic                   clk, rst;
   logic [`ADDR_WIDTH-1:0] i_MAddr;
   logic [2:0]             i_MCmd;
   logic [`DATA_WIDTH-1:0] i_MData;
   logic [`BEN_WIDTH-1:0]  i_MByteEn;
   logic                   i_SCmdAccept;
   logic [`DATA_WIDTH-1:0] i_SData;
   logic [1:0]             i_SResp;

   logic                   acc_a, acc_b;
   logic [`DATA_WIDTH-1:0] sdata_a, sdata_b, mdata_a, mdata_b;
   logic [1:0]             sresp_a, sresp_b;
   logic [`ADDR_WIDTH-1:0] maddr_a, maddr_b;
   logic [2:0]             mcmd_a, mcmd_b;
   logic [`BEN_WIDTH-1:0]  mben_a, mben_b;

   int total = 0;
   int bad   = 0;

   ocp_slave_slice #(.TIMEOUT(8)) dut_a (
      .clk(clk), .rst(rst),
      .i_MAddr(i_MAddr), .i_MCmd(i_MCmd), .i_MData(i_MData), .i_MByteEn(i_MByteEn),
      .o_SCmdAccept(acc_a), .o_SData(sdata_a), .o_SResp(sresp_a),
      .o_MAddr(maddr_a), .o_MCmd(mcmd_a), .o_MData(mdata_a), .o_MByteEn(mben_a),
      .i_SCmdAccept(i_SCmdAccept), .i_SData(i_SData), .i_SResp(i_SResp)
   );

   ocp_slave_slice #(.TIMEOUT(0)) dut_b (
      .clk(clk), .rst(rst),
      .i_MAddr(i_MAddr), .i_MCmd(i_MCmd), .i_MData(i_MData), .i_MByteEn(i_MByteEn),
      .o_SCmdAccept(acc_b), .o_SData(sdata_b), .o_SResp(sresp_b),
      .o_MAddr(maddr_b), .o_MCmd(mcmd_b), .o_MData(mdata_b), .o_MByteEn(mben_b),
      .i_SCmdAccept(i_SCmdAccept), .i_SData(i_SData), .i_SResp(i_SResp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic slave_idle();
      i_SCmdAccept = 1'b0;
      i_SResp      = `OCP_RESP_NULL;
      i_SData      = '0;
   endtask

   task automatic test_reset();
      tick(); #1;
      total++; if (acc_a !== 1'b0) begin bad++; $display("FAIL rst_accept got=%0h exp=0", acc_a); end
      total++; if (mcmd_a !== `OCP_CMD_IDLE) begin bad++; $display("FAIL rst_mcmd got=%0h exp=0", mcmd_a); end
      total++; if (maddr_a !== 0 || mdata_a !== 0 || mben_a !== 0) begin bad++; $display("FAIL rst_mregs got=%0h/%0h/%0h exp=0", maddr_a, mdata_a, mben_a); end
      total++; if (sresp_a !== `OCP_RESP_NULL || sdata_a !== 0) begin bad++; $display("FAIL rst_sresp got=%0h/%0h exp=0/0", sresp_a, sdata_a); end
      rst = 1'b0; #1;
      total++; if (acc_a !== 1'b1 || acc_b !== 1'b1) begin bad++; $display("FAIL rst_release_accept got=%0h/%0h exp=1/1", acc_a, acc_b); end
      tick();
   endtask

   task automatic test_read(input logic [`ADDR_WIDTH-1:0] addr, input logic [`DATA_WIDTH-1:0] data);
      i_MCmd = `OCP_CMD_RD; i_MAddr = addr; i_MData = '0; i_MByteEn = '1; #1;
      total++; if (acc_a !== 1'b1) begin bad++; $display("FAIL rd_accept_n got=%0h exp=1", acc_a); end
      tick();
      i_MCmd = `OCP_CMD_IDLE; i_SCmdAccept = 1'b1; i_SResp = `OCP_RESP_DVA; i_SData = data; #1;
      total++; if (mcmd_a !== `OCP_CMD_RD) begin bad++; $display("FAIL rd_mcmd_n1 got=%0h exp=%0h", mcmd_a, `OCP_CMD_RD); end
      total++; if (maddr_a !== addr) begin bad++; $display("FAIL rd_maddr_n1 got=%0h exp=%0h", maddr_a, addr); end
      total++; if (acc_a !== 1'b0 || sresp_a !== `OCP_RESP_NULL) begin bad++; $display("FAIL rd_n1_side got=%0h/%0h exp=0/0", acc_a, sresp_a); end
      tick();
      slave_idle(); #1;
      total++; if (sresp_a !== `OCP_RESP_DVA) begin bad++; $display("FAIL rd_sresp_n2 got=%0h exp=%0h", sresp_a, `OCP_RESP_DVA); end
      total++; if (sdata_a !== data) begin bad++; $display("FAIL rd_sdata_n2 got=%0h exp=%0h", sdata_a, data); end
      total++; if (mcmd_a !== `OCP_CMD_IDLE) begin bad++; $display("FAIL rd_mcmd_n2 got=%0h exp=0", mcmd_a); end
      tick(); #1;
      total++; if (sresp_a !== `OCP_RESP_NULL || sdata_a !== 0) begin bad++; $display("FAIL rd_pulse_end got=%0h/%0h exp=0/0", sresp_a, sdata_a); end
      total++; if (acc_a !== 1'b1) begin bad++; $display("FAIL rd_accept_n3 got=%0h exp=1", acc_a); end
   endtask

   task automatic test_write();
      i_MCmd = `OCP_CMD_WR; i_MAddr = 32'h100; i_MData = 32'h0000_00A5; i_MByteEn = 4'h1; #1;
      total++; if (acc_a !== 1'b1) begin bad++; $display("FAIL wr_accept_n got=%0h exp=1", acc_a); end
      tick();
      i_MCmd = `OCP_CMD_IDLE; i_MData = '0; i_SCmdAccept = 1'b1; i_SResp = `OCP_RESP_DVA; i_SData = '0; #1;
      total++; if (mdata_a !== 32'hA5 || maddr_a !== 32'h100 || mben_a !== 4'h1) begin bad++; $display("FAIL wr_m_n1 got=%0h/%0h/%0h exp=a5/100/1", mdata_a, maddr_a, mben_a); end
      total++; if (mcmd_a !== `OCP_CMD_WR) begin bad++; $display("FAIL wr_mcmd_n1 got=%0h exp=%0h", mcmd_a, `OCP_CMD_WR); end
      total++; if (acc_a !== 1'b0) begin bad++; $display("FAIL wr_accept_n1 got=%0h exp=0", acc_a); end
      tick();
      slave_idle(); #1;
      total++; if (sresp_a !== `OCP_RESP_DVA || sdata_a !== 0) begin bad++; $display("FAIL wr_resp_n2 got=%0h/%0h exp=1/0", sresp_a, sdata_a); end
      total++; if (acc_a !== 1'b0) begin bad++; $display("FAIL wr_accept_n2 got=%0h exp=0", acc_a); end
      tick(); #1;
      total++; if (acc_a !== 1'b1) begin bad++; $display("FAIL wr_accept_n3 got=%0h exp=1", acc_a); end
   endtask

   task automatic test_stall();
      i_MCmd = `OCP_CMD_RD; i_MAddr = 32'h44; #1;
      tick();
      i_MCmd = `OCP_CMD_IDLE; i_MAddr = 32'hFFFF;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) begin i_SCmdAccept = 1'b1; i_SResp = `OCP_RESP_DVA; i_SData = 32'h1234; end
         #1;
         total++; if (mcmd_a !== `OCP_CMD_RD || maddr_a !== 32'h44) begin bad++; $display("FAIL stall_hold[%0d] got=%0h/%0h exp=2/44", k, mcmd_a, maddr_a); end
         total++; if (sresp_a !== `OCP_RESP_NULL) begin bad++; $display("FAIL stall_noresp[%0d] got=%0h exp=0", k, sresp_a); end
         tick();
      end
      slave_idle(); #1;
      total++; if (sresp_a !== `OCP_RESP_DVA || sdata_a !== 32'h1234) begin bad++; $display("FAIL stall_resp got=%0h/%0h exp=1/1234", sresp_a, sdata_a); end
      tick(); #1;
      total++; if (acc_a !== 1'b1 || sresp_a !== `OCP_RESP_NULL) begin bad++; $display("FAIL stall_idle got=%0h/%0h exp=1/0", acc_a, sresp_a); end
   endtask

   task automatic test_wait();
      i_MCmd = `OCP_CMD_RD; i_MAddr = 32'h8; #1;
      tick();
      i_MCmd = `OCP_CMD_IDLE; i_SCmdAccept = 1'b1; i_SResp = `OCP_RESP_NULL; #1;
      total++; if (mcmd_a !== `OCP_CMD_RD) begin bad++; $display("FAIL wait_req_mcmd got=%0h exp=2", mcmd_a); end
      tick();
      for (int k = 0; k < 3; k++) begin
         i_SCmdAccept = 1'b0;
         if (k == 2) begin i_SResp = `OCP_RESP_DVA; i_SData = 32'hBEEF; end
         #1;
         total++; if (mcmd_a !== `OCP_CMD_IDLE || maddr_a !== 32'h8) begin bad++; $display("FAIL wait_mcmd[%0d] got=%0h/%0h exp=0/8", k, mcmd_a, maddr_a); end
         total++; if (sresp_a !== `OCP_RESP_NULL) begin bad++; $display("FAIL wait_noresp[%0d] got=%0h exp=0", k, sresp_a); end
         tick();
      end
      slave_idle(); #1;
      total++; if (sresp_a !== `OCP_RESP_DVA || sdata_a !== 32'hBEEF) begin bad++; $display("FAIL wait_resp got=%0h/%0h exp=1/beef", sresp_a, sdata_a); end
      tick(); #1;
   endtask

   task automatic test_timeout();
      logic seen_b;
      seen_b = 1'b0;
      i_MCmd = `OCP_CMD_RD; i_MAddr = 32'h200; #1;
      total++; if (acc_a !== 1'b1 || acc_b !== 1'b1) begin bad++; $display("FAIL to_accept got=%0h/%0h exp=1/1", acc_a, acc_b); end
      tick();
      i_MCmd = `OCP_CMD_IDLE; slave_idle();
      for (int k = 1; k <= 8; k++) begin
         #1;
         total++; if (sresp_a !== `OCP_RESP_NULL || mcmd_a !== `OCP_CMD_RD) begin bad++; $display("FAIL to_pending[%0d] got=%0h/%0h exp=0/2", k, sresp_a, mcmd_a); end
         tick();
      end
      #1;
      total++; if (sresp_a !== `OCP_RESP_ERR || sdata_a !== 0) begin bad++; $display("FAIL to_err got=%0h/%0h exp=3/0", sresp_a, sdata_a); end
      total++; if (mcmd_a !== `OCP_CMD_IDLE) begin bad++; $display("FAIL to_mcmd_drop got=%0h exp=0", mcmd_a); end
      tick(); #1;
      total++; if (acc_a !== 1'b1 || sresp_a !== `OCP_RESP_NULL) begin bad++; $display("FAIL to_back_idle got=%0h/%0h exp=1/0", acc_a, sresp_a); end
      for (int k = 10; k < 1000; k++) begin
         if (sresp_b !== `OCP_RESP_NULL) seen_b = 1'b1;
         tick();
      end
      #1;
      total++; if (seen_b !== 1'b0) begin bad++; $display("FAIL to_disabled_resp got=%0h exp=0", seen_b); end
      total++; if (mcmd_b !== `OCP_CMD_RD || acc_b !== 1'b0) begin bad++; $display("FAIL to_disabled_hold got=%0h/%0h exp=2/0", mcmd_b, acc_b); end
   endtask

   task automatic test_reset_mid();
      i_MCmd = `OCP_CMD_RD; i_MAddr = 32'h20; #1;
      tick();
      i_MCmd = `OCP_CMD_IDLE; i_SCmdAccept = 1'b1; i_SResp = `OCP_RESP_NULL; #1;
      tick();
      i_SCmdAccept = 1'b0; #1;
      total++; if (mcmd_a !== `OCP_CMD_IDLE || maddr_a !== 32'h20) begin bad++; $display("FAIL rm_in_wait got=%0h/%0h exp=0/20", mcmd_a, maddr_a); end
      rst = 1'b1; i_SResp = `OCP_RESP_DVA; i_SData = 32'h55; #1;
      total++; if (maddr_a !== 0 || acc_a !== 1'b0 || mcmd_a !== `OCP_CMD_IDLE) begin bad++; $display("FAIL rm_async got=%0h/%0h/%0h exp=0/0/0", maddr_a, acc_a, mcmd_a); end
      total++; if (sresp_a !== `OCP_RESP_NULL || sdata_a !== 0) begin bad++; $display("FAIL rm_async_resp got=%0h/%0h exp=0/0", sresp_a, sdata_a); end
      tick();
      rst = 1'b0; slave_idle(); #1;
      total++; if (acc_a !== 1'b1 || sresp_a !== `OCP_RESP_NULL) begin bad++; $display("FAIL rm_after got=%0h/%0h exp=1/0", acc_a, sresp_a); end
      tick(); #1;
      total++; if (sresp_a !== `OCP_RESP_NULL) begin bad++; $display("FAIL rm_no_resp got=%0h exp=0", sresp_a); end
      test_read(32'h4, 32'h0000_CAFE);
   endtask

   initial begin
      rst = 1'b1;
      i_MCmd = `OCP_CMD_IDLE; i_MAddr = '0; i_MData = '0; i_MByteEn = '0;
      slave_idle();
      test_reset();
      test_read(32'h0, 32'h0001_0000);
      tick();
      test_write();
      tick();
      test_read(32'h3C, 32'($urandom_range(1, 32'hFFFF)));
      tick();
      test_stall();
      tick();
      test_wait();
      test_timeout();
      tick();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
